fir_seq_ctrl: RTL and testbench

Sequencer that drives the SCIEPipelined FIR accelerator through its custom-instruction port (insn/rs1/rs2/valid -> rd). It converts two valid/ready streams into correctly timed accelerator instruction sequences: coefficient writes and input samples. It returns one filtered output per sample on a valid/ready result stream. It sits between a host-side DMA/queue and the accelerator, so software no longer hand-times PUSH/READ gaps.

---
 rtl/fir_seq_ctrl_if.sv | 32 +++
 rtl/fir_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// Stream and accelerator-port bundle for fir_seq_ctrl.
// The sequencer takes the master view; the host/accelerator side takes the slave view.
interface fir_seq_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int IDX_W = 3
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [IDX_W-1:0] cfg_idx;
   logic [XLEN-1:0]  cfg_coef;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_data;
   logic             acc_valid;
   logic [31:0]      acc_insn;
   logic [XLEN-1:0]  acc_rs1;
   logic [XLEN-1:0]  acc_rs2;
   logic [XLEN-1:0]  acc_rd;

   modport master (
      input  cfg_valid, cfg_idx, cfg_coef, in_valid, in_data, out_ready, acc_rd,
      output cfg_ready, in_ready, out_valid, out_data, acc_valid, acc_insn, acc_rs1, acc_rs2
   );

   modport slave (
      output cfg_valid, cfg_idx, cfg_coef, in_valid, in_data, out_ready, acc_rd,
      input  cfg_ready, in_ready, out_valid, out_data, acc_valid, acc_insn, acc_rs1, acc_rs2
   );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencer turning coefficient/sample streams into timed COEF/PUSH/READ accelerator ops.
// One sample in flight; the result is returned on the out stream.
module fir_seq_ctrl #(
   parameter int XLEN    = 32,
   parameter int TAPS    = 5,
   parameter int IDX_W   = 3,
   parameter int GAP_CYC = 1,
   parameter int RD_LAT  = 1,
   parameter int OP_COEF = 11,
   parameter int OP_PUSH = 43,
   parameter int OP_READ = 91,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   fir_seq_ctrl_if.master   bus,
   output logic             busy,
   output logic             cfg_err,
   output logic [CNT_W-1:0] sample_cnt
);

   typedef enum logic [2:0] {IDLE, COEF, PUSH, GAP, READ, OUT} state_t;

   state_t           r_state, w_nxt;
   logic [3:0]       r_gap_cnt;
   logic [2:0]       r_rd_cnt;
   logic             r_acc_valid, w_acc_valid;
   logic [31:0]      r_acc_insn, w_acc_insn;
   logic [XLEN-1:0]  r_acc_rs1, w_acc_rs1;
   logic [XLEN-1:0]  r_acc_rs2, w_acc_rs2;
   logic             r_out_valid;
   logic [XLEN-1:0]  r_out_data;
   logic             r_cfg_err;
   logic [CNT_W-1:0] r_sample_cnt;
   logic             w_idx_ok, w_cfg_bad, w_rd_last, w_out_hs;

   assign w_idx_ok  = int'(bus.cfg_idx) < TAPS;
   assign w_cfg_bad = (r_state == IDLE) && bus.cfg_valid && !w_idx_ok;
   assign w_rd_last = (r_state == READ) && (r_rd_cnt == 3'd0);
   assign w_out_hs  = (r_state == OUT) && bus.out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nxt;
   end

   // acc_* are registered, so the op for the next state is decoded here and flopped.
   always_comb begin
      w_nxt         = r_state;
      w_acc_valid   = 1'b0;
      w_acc_insn    = '0;
      w_acc_rs1     = '0;
      w_acc_rs2     = '0;
      bus.cfg_ready = 1'b0;
      bus.in_ready  = 1'b0;
      case (r_state)
         IDLE: begin
            bus.cfg_ready = 1'b1;
            bus.in_ready  = !bus.cfg_valid;
            if (bus.cfg_valid) begin
               if (w_idx_ok) begin
                  w_nxt       = COEF;
                  w_acc_valid = 1'b1;
                  w_acc_insn  = 32'(OP_COEF);
                  w_acc_rs1   = bus.cfg_coef;
                  w_acc_rs2   = XLEN'(bus.cfg_idx);
               end
            end else if (bus.in_valid) begin
               w_nxt       = PUSH;
               w_acc_valid = 1'b1;
               w_acc_insn  = 32'(OP_PUSH);
               w_acc_rs1   = bus.in_data;
            end
         end
         COEF: w_nxt = IDLE;
         PUSH: begin
            if (GAP_CYC == 0) begin
               w_nxt       = READ;
               w_acc_valid = 1'b1;
               w_acc_insn  = 32'(OP_READ);
            end else begin
               w_nxt = GAP;
            end
         end
         GAP: begin
            if (r_gap_cnt == 4'd0) begin
               w_nxt       = READ;
               w_acc_valid = 1'b1;
               w_acc_insn  = 32'(OP_READ);
            end
         end
         READ: begin
            if (r_rd_cnt == 3'd0) begin
               w_nxt = OUT;
            end else begin
               w_acc_valid = 1'b1;
               w_acc_insn  = 32'(OP_READ);
            end
         end
         OUT:     if (bus.out_ready) w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_acc_valid  <= 1'b0;
         r_acc_insn   <= '0;
         r_acc_rs1    <= '0;
         r_acc_rs2    <= '0;
         r_gap_cnt    <= '0;
         r_rd_cnt     <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_cfg_err    <= 1'b0;
         r_sample_cnt <= '0;
      end else begin
         r_acc_valid <= w_acc_valid;
         r_acc_insn  <= w_acc_insn;
         r_acc_rs1   <= w_acc_rs1;
         r_acc_rs2   <= w_acc_rs2;
         // Counters preload while outside their state and count down inside it.
         if (r_state != GAP)          r_gap_cnt <= 4'(GAP_CYC - 1);
         else                         r_gap_cnt <= r_gap_cnt - 4'd1;
         if (r_state != READ)         r_rd_cnt  <= 3'(RD_LAT);
         else if (r_rd_cnt != 3'd0)   r_rd_cnt  <= r_rd_cnt - 3'd1;
         if (w_rd_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.acc_rd;
         end else if (w_out_hs) begin
            r_out_valid  <= 1'b0;
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
         end
         if (w_cfg_bad) r_cfg_err <= 1'b1;
      end
   end

   assign bus.acc_valid = r_acc_valid;
   assign bus.acc_insn  = r_acc_insn;
   assign bus.acc_rs1   = r_acc_rs1;
   assign bus.acc_rs2   = r_acc_rs2;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign busy          = (r_state != IDLE);
   assign cfg_err       = r_cfg_err;
   assign sample_cnt    = r_sample_cnt;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl: a FIR accelerator model on the default instance,
// echo-style accelerator models on a GAP_CYC=0/RD_LAT=3 instance and a CNT_W=2 instance.
module tb_fir_seq_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int n_pass = 0;
   int n_chk  = 0;
   logic [31:0] exp_q[$];

   fir_seq_ctrl_if #(.XLEN(32), .IDX_W(3)) ifA ();
   fir_seq_ctrl_if #(.XLEN(32), .IDX_W(3)) ifB ();
   fir_seq_ctrl_if #(.XLEN(32), .IDX_W(3)) ifC ();
   logic busyA, busyB, busyC, errA, errB, errC;
   logic [15:0] cntA, cntB;
   logic [1:0]  cntC;

   fir_seq_ctrl uA (.clock(clock), .reset(reset), .bus(ifA), .busy(busyA), .cfg_err(errA), .sample_cnt(cntA));
   fir_seq_ctrl #(.GAP_CYC(0), .RD_LAT(3)) uB (.clock(clock), .reset(reset), .bus(ifB), .busy(busyB), .cfg_err(errB), .sample_cnt(cntB));
   fir_seq_ctrl #(.CNT_W(2)) uC (.clock(clock), .reset(reset), .bus(ifC), .busy(busyC), .cfg_err(errC), .sample_cnt(cntC));

   // FIR accelerator model: y = sum c[i]*x[n-i]; rd valid RD_LAT cycles into a READ.
   logic [31:0] cA[5] = '{default: '0};
   logic [31:0] hA[5] = '{default: '0};
   logic [31:0] sumA;
   int rcA = 0, rcB = 0, rcC = 0, opsA = 0, opsB = 0, opsC = 0;
   logic [31:0] echoB = '0, echoC = '0;

   always @(posedge clock) begin
      if (ifA.acc_valid && ifA.acc_insn == 32'd11 && ifA.acc_rs2 < 32'd5) cA[ifA.acc_rs2[2:0]] <= ifA.acc_rs1;
      if (ifA.acc_valid && ifA.acc_insn == 32'd43) begin
         for (int i = 4; i > 0; i--) hA[i] <= hA[i-1];
         hA[0] <= ifA.acc_rs1;
      end
      rcA <= (ifA.acc_valid && ifA.acc_insn == 32'd91) ? rcA + 1 : 0;
      rcB <= (ifB.acc_valid && ifB.acc_insn == 32'd91) ? rcB + 1 : 0;
      rcC <= (ifC.acc_valid && ifC.acc_insn == 32'd91) ? rcC + 1 : 0;
      if (ifB.acc_valid && ifB.acc_insn == 32'd43) echoB <= ifB.acc_rs1;
      if (ifC.acc_valid && ifC.acc_insn == 32'd43) echoC <= ifC.acc_rs1;
      if (ifA.acc_valid) opsA <= opsA + 1;
      if (ifB.acc_valid) opsB <= opsB + 1;
      if (ifC.acc_valid) opsC <= opsC + 1;
   end

   always_comb begin
      sumA = '0;
      for (int i = 0; i < 5; i++) sumA = sumA + cA[i] * hA[i];
      ifA.acc_rd = (rcA >= 1) ? sumA : 32'hDEAD_BEEF;
      ifB.acc_rd = (rcB >= 3) ? (echoB ^ 32'h5A5A_0000) : 32'hDEAD_BEEF;
      ifC.acc_rd = (rcC >= 1) ? (echoC ^ 32'h5A5A_0000) : 32'hDEAD_BEEF;
   end

   int coefs[5]   = '{6, 80, 79, 8, 24};
   int samples[5] = '{48, 62, 75, 24, 42};
   int fir_exp[5] = '{288, 4212, 9202, 11426, 9745};

   task automatic tick;
      @(posedge clock);
      #2;
   endtask

   task automatic test_reset;
      tick;
      n_chk++; if (ifA.acc_valid !== 1'b0 || ifA.acc_insn !== 32'd0 || ifA.acc_rs1 !== 32'd0 || ifA.acc_rs2 !== 32'd0)
         $display("FAIL rst_acc got v=%0d insn=%0d rs1=%0d rs2=%0d exp all 0", ifA.acc_valid, ifA.acc_insn, ifA.acc_rs1, ifA.acc_rs2); else n_pass++;
      n_chk++; if (ifA.out_valid !== 1'b0 || ifA.out_data !== 32'd0) $display("FAIL rst_out got v=%0d d=%0d exp 0", ifA.out_valid, ifA.out_data); else n_pass++;
      n_chk++; if (busyA !== 1'b0 || errA !== 1'b0 || cntA !== 16'd0) $display("FAIL rst_status got busy=%0d err=%0d cnt=%0d exp 0", busyA, errA, cntA); else n_pass++;
      tick;
      reset = 1'b0;
      repeat (5) tick;
      n_chk++; if (opsA + opsB + opsC != 0) $display("FAIL rst_no_ops got %0d ops exp 0", opsA + opsB + opsC); else n_pass++;
   endtask

   task automatic test_coef_load;
      for (int k = 0; k < 5; k++) begin
         ifA.cfg_valid = 1'b1; ifA.cfg_idx = 3'(k); ifA.cfg_coef = 32'(coefs[k]);
         #1;
         n_chk++; if (ifA.cfg_ready !== 1'b1) $display("FAIL coef_ready k=%0d got %0d exp 1", k, ifA.cfg_ready); else n_pass++;
         tick;
         n_chk++; if (ifA.acc_valid !== 1'b1 || ifA.acc_insn !== 32'd11 || ifA.acc_rs1 !== 32'(coefs[k]) || ifA.acc_rs2 !== 32'(k))
            $display("FAIL coef_pulse k=%0d got v=%0d insn=%0d rs1=%0d rs2=%0d exp 1/11/%0d/%0d", k, ifA.acc_valid, ifA.acc_insn, ifA.acc_rs1, ifA.acc_rs2, coefs[k], k); else n_pass++;
         tick;
         n_chk++; if (ifA.acc_valid !== 1'b0) $display("FAIL coef_space k=%0d got v=%0d exp 0", k, ifA.acc_valid); else n_pass++;
      end
      ifA.cfg_valid = 1'b0;
      n_chk++; if (opsA != 5) $display("FAIL coef_count got %0d exp 5", opsA); else n_pass++;
      ifA.cfg_valid = 1'b1; ifA.cfg_idx = 3'd5; ifA.cfg_coef = 32'd999;
      tick;
      ifA.cfg_valid = 1'b0;
      n_chk++; if (ifA.acc_valid !== 1'b0 || busyA !== 1'b0 || errA !== 1'b1)
         $display("FAIL coef_bad_idx got v=%0d busy=%0d err=%0d exp 0/0/1", ifA.acc_valid, busyA, errA); else n_pass++;
      repeat (3) tick;
      n_chk++; if (errA !== 1'b1 || opsA != 5) $display("FAIL coef_err_sticky got err=%0d ops=%0d exp 1/5", errA, opsA); else n_pass++;
   endtask

   task automatic test_fir_stream;
      int lat;
      logic [31:0] expv;
      ifA.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ifA.in_valid = 1'b1; ifA.in_data = 32'(samples[k]);
         #1;
         n_chk++; if (ifA.in_ready !== 1'b1) $display("FAIL fir_in_ready k=%0d got %0d exp 1", k, ifA.in_ready); else n_pass++;
         exp_q.push_back(32'(fir_exp[k]));
         tick;
         ifA.in_valid = 1'b0;
         n_chk++; if (ifA.acc_valid !== 1'b1 || ifA.acc_insn !== 32'd43 || ifA.acc_rs1 !== 32'(samples[k]))
            $display("FAIL fir_push k=%0d got v=%0d insn=%0d rs1=%0d exp 1/43/%0d", k, ifA.acc_valid, ifA.acc_insn, ifA.acc_rs1, samples[k]); else n_pass++;
         lat = 0;
         while (!ifA.out_valid && lat < 20) begin
            tick; lat++;
            if (lat == 1) begin
               n_chk++; if (ifA.acc_valid !== 1'b0) $display("FAIL fir_gap k=%0d got v=%0d exp 0", k, ifA.acc_valid); else n_pass++;
            end else if (!ifA.out_valid) begin
               n_chk++; if (ifA.acc_valid !== 1'b1 || ifA.acc_insn !== 32'd91)
                  $display("FAIL fir_read k=%0d c=%0d got v=%0d insn=%0d exp 1/91", k, lat, ifA.acc_valid, ifA.acc_insn); else n_pass++;
            end
         end
         n_chk++; if (lat != 4) $display("FAIL fir_latency k=%0d got %0d exp 4", k, lat); else n_pass++;
         expv = exp_q.pop_front();
         n_chk++; if (ifA.out_valid !== 1'b1 || ifA.out_data !== expv)
            $display("FAIL fir_result k=%0d got v=%0d d=%0d exp 1/%0d", k, ifA.out_valid, ifA.out_data, expv); else n_pass++;
         tick;
         n_chk++; if (ifA.out_valid !== 1'b0) $display("FAIL fir_out_drop k=%0d got %0d exp 0", k, ifA.out_valid); else n_pass++;
      end
      n_chk++; if (cntA !== 16'd5) $display("FAIL fir_cnt got %0d exp 5", cntA); else n_pass++;
   endtask

   task automatic test_priority_backpressure;
      int lat, ops0;
      logic [31:0] data0, expv;
      ifA.cfg_valid = 1'b1; ifA.cfg_idx = 3'd0; ifA.cfg_coef = 32'd6;
      ifA.in_valid = 1'b1; ifA.in_data = 32'd10;
      #1;
      n_chk++; if (ifA.in_ready !== 1'b0 || ifA.cfg_ready !== 1'b1)
         $display("FAIL prio_ready got in=%0d cfg=%0d exp 0/1", ifA.in_ready, ifA.cfg_ready); else n_pass++;
      tick;
      n_chk++; if (ifA.acc_valid !== 1'b1 || ifA.acc_insn !== 32'd11) $display("FAIL prio_coef_first got v=%0d insn=%0d exp 1/11", ifA.acc_valid, ifA.acc_insn); else n_pass++;
      ifA.cfg_valid = 1'b0;
      tick;
      #1;
      n_chk++; if (ifA.in_ready !== 1'b1) $display("FAIL prio_in_ready got %0d exp 1", ifA.in_ready); else n_pass++;
      exp_q.push_back(32'd7404);
      tick;
      n_chk++; if (ifA.acc_insn !== 32'd43 || ifA.acc_rs1 !== 32'd10) $display("FAIL prio_sample_next got insn=%0d rs1=%0d exp 43/10", ifA.acc_insn, ifA.acc_rs1); else n_pass++;
      ifA.in_valid = 1'b0; ifA.out_ready = 1'b0;
      lat = 0;
      while (!ifA.out_valid && lat < 20) begin tick; lat++; end
      n_chk++; if (lat != 4) $display("FAIL bp_latency got %0d exp 4", lat); else n_pass++;
      data0 = ifA.out_data; ops0 = opsA;
      ifA.in_valid = 1'b1; ifA.in_data = 32'd99;
      for (int c = 0; c < 10; c++) begin
         tick;
         n_chk++; if (ifA.out_valid !== 1'b1 || ifA.out_data !== data0 || ifA.in_ready !== 1'b0)
            $display("FAIL bp_hold c=%0d got v=%0d d=%0d in_rdy=%0d exp 1/%0d/0", c, ifA.out_valid, ifA.out_data, ifA.in_ready, data0); else n_pass++;
      end
      n_chk++; if (opsA != ops0) $display("FAIL bp_no_acc got %0d ops exp %0d", opsA, ops0); else n_pass++;
      expv = exp_q.pop_front();
      n_chk++; if (ifA.out_data !== expv) $display("FAIL bp_data got %0d exp %0d", ifA.out_data, expv); else n_pass++;
      ifA.out_ready = 1'b1;
      #1;
      n_chk++; if (ifA.in_ready !== 1'b0) $display("FAIL hs_no_accept got %0d exp 0", ifA.in_ready); else n_pass++;
      tick;
      ifA.in_valid = 1'b0;
      n_chk++; if (ifA.out_valid !== 1'b0 || cntA !== 16'd6 || busyA !== 1'b0)
         $display("FAIL bp_release got v=%0d cnt=%0d busy=%0d exp 0/6/0", ifA.out_valid, cntA, busyA); else n_pass++;
   endtask

   task automatic test_gap0_rd3;
      logic [31:0] s[3] = '{32'h0000_1234, 32'hFFFF_FFFF, 32'h8000_0001};
      logic [31:0] expv;
      int lat;
      ifB.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ifB.in_valid = 1'b1; ifB.in_data = s[k];
         exp_q.push_back(s[k] ^ 32'h5A5A_0000);
         tick;
         ifB.in_valid = 1'b0;
         n_chk++; if (ifB.acc_valid !== 1'b1 || ifB.acc_insn !== 32'd43) $display("FAIL g0_push k=%0d got v=%0d insn=%0d exp 1/43", k, ifB.acc_valid, ifB.acc_insn); else n_pass++;
         lat = 0;
         while (!ifB.out_valid && lat < 20) begin
            tick; lat++;
            if (!ifB.out_valid) begin
               n_chk++; if (ifB.acc_valid !== 1'b1 || ifB.acc_insn !== 32'd91)
                  $display("FAIL g0_read k=%0d c=%0d got v=%0d insn=%0d exp 1/91", k, lat, ifB.acc_valid, ifB.acc_insn); else n_pass++;
            end
         end
         n_chk++; if (lat != 5) $display("FAIL g0_latency k=%0d got %0d exp 5", k, lat); else n_pass++;
         expv = exp_q.pop_front();
         n_chk++; if (ifB.out_data !== expv || ifB.acc_valid !== 1'b0)
            $display("FAIL g0_result k=%0d got d=%0h v=%0d exp %0h/0", k, ifB.out_data, ifB.acc_valid, expv); else n_pass++;
         tick;
      end
      n_chk++; if (cntB !== 16'd3) $display("FAIL g0_cnt got %0d exp 3", cntB); else n_pass++;
   endtask

   task automatic test_cnt_wrap;
      logic [31:0] expv;
      int lat;
      ifC.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ifC.in_valid = 1'b1; ifC.in_data = 32'(k * 3 + 1);
         exp_q.push_back(32'(k * 3 + 1) ^ 32'h5A5A_0000);
         tick;
         ifC.in_valid = 1'b0;
         lat = 0;
         while (!ifC.out_valid && lat < 20) begin tick; lat++; end
         expv = exp_q.pop_front();
         n_chk++; if (ifC.out_valid !== 1'b1 || ifC.out_data !== expv)
            $display("FAIL wrap_result k=%0d got v=%0d d=%0h exp 1/%0h", k, ifC.out_valid, ifC.out_data, expv); else n_pass++;
         tick;
      end
      n_chk++; if (cntC !== 2'd1) $display("FAIL wrap_cnt got %0d exp 1", cntC); else n_pass++;
   endtask

   task automatic test_mid_read_reset;
      int ops0;
      ifA.in_valid = 1'b1; ifA.in_data = 32'd7;
      tick;
      ifA.in_valid = 1'b0;
      tick; tick;
      n_chk++; if (ifA.acc_valid !== 1'b1 || ifA.acc_insn !== 32'd91) $display("FAIL pre_rst_read got v=%0d insn=%0d exp 1/91", ifA.acc_valid, ifA.acc_insn); else n_pass++;
      #1 reset = 1'b1;
      #1;
      n_chk++; if (ifA.acc_valid !== 1'b0 || ifA.out_valid !== 1'b0 || busyA !== 1'b0 || cntA !== 16'd0)
         $display("FAIL rst_async got acc_v=%0d out_v=%0d busy=%0d cnt=%0d exp 0", ifA.acc_valid, ifA.out_valid, busyA, cntA); else n_pass++;
      tick; tick;
      reset = 1'b0;
      ops0 = opsA;
      repeat (6) tick;
      n_chk++; if (opsA != ops0 || busyA !== 1'b0 || ifA.out_valid !== 1'b0)
         $display("FAIL post_rst_quiet got ops=%0d busy=%0d out_v=%0d exp %0d/0/0", opsA, busyA, ifA.out_valid, ops0); else n_pass++;
   endtask

   initial begin
      ifA.cfg_valid = 0; ifA.cfg_idx = 0; ifA.cfg_coef = 0; ifA.in_valid = 0; ifA.in_data = 0; ifA.out_ready = 0;
      ifB.cfg_valid = 0; ifB.cfg_idx = 0; ifB.cfg_coef = 0; ifB.in_valid = 0; ifB.in_data = 0; ifB.out_ready = 0;
      ifC.cfg_valid = 0; ifC.cfg_idx = 0; ifC.cfg_coef = 0; ifC.in_valid = 0; ifC.in_data = 0; ifC.out_ready = 0;
      test_reset;
      test_coef_load;
      test_fir_stream;
      test_priority_backpressure;
      test_gap0_rd3;
      test_cnt_wrap;
      test_mid_read_reset;
      n_chk++; if (exp_q.size() != 0) $display("FAIL scoreboard_left got %0d entries exp 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
